spi_slave_regfile: RTL
======================

Name: spi_slave_regfile

Overview:
- Parametrised SPI slave for the GPIO-bank SPI pins (sclk, mosi, cs, miso), clocked entirely by the 50 MHz system clock.
- Oversamples the SPI pins and decodes a command/data protocol into an internal register file of 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Supports burst auto-increment reads and writes and all four SPI modes.
- Exposes a local read port (e.g. to drive led) and a one-cycle write-notify strobe for top-level logic.

Parameters:
DATA_WIDTH, 8, bits per register word and per SPI data word (1..32)
ADDR_WIDTH, 4, register file address width, depth = 2^ADDR_WIDTH (1..7)
CPOL, 0, idle sclk level; leading edge is rising when 0, falling when 1
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge
SYNC_STAGES, 2, flip-flop stages on sclk/mosi/cs (>=2)

Ports:
clk  input  1  50 MHz system clock
reset_n  input  1  synchronous active-low reset
sclk  input  1  SPI clock from master, asynchronous
mosi  input  1  SPI data in, asynchronous
cs  input  1  SPI chip select, active-low, asynchronous
miso  output  1  SPI data out, registered
local_addr  input  ADDR_WIDTH  local read address
local_rdata  output  DATA_WIDTH  combinational read of regfile[local_addr]
wr_valid  output  1  one-cycle pulse on each completed SPI word write
wr_addr  output  ADDR_WIDTH  address of the write, valid with wr_valid
wr_data  output  DATA_WIDTH  data of the write, valid with wr_valid
frame_done  output  1  one-cycle pulse when cs deasserts after a frame

Behaviour:
- Reset (reset_n low at a clk edge): every regfile word = 0; miso = 0; wr_valid, frame_done = 0; wr_addr, wr_data = 0; FSM = IDLE; bit counter, shift registers and address pointer = 0. Reset has priority over every other event, including reset mid-frame.
- Synchronisation: sclk, mosi and cs each pass through SYNC_STAGES flip-flops. Edges are detected by comparing the last synchronised sample with the previous one, so the SPI-to-internal latency is SYNC_STAGES+1 clk. sclk must be at most clk/8 (6.25 MHz at 50 MHz). mosi is taken from the same synchronised stage as sclk.
- Edge mapping: sample_edge = leading edge if CPHA=0, else trailing. shift_edge = the opposite edge.
- FSM:
  - IDLE -> CMD when synchronised cs falls. Clear the bit counter and rx shift register.
  - CMD: 8 sample edges, MSB first. bit7 = RW (1 = read); bits[ADDR_WIDTH-1:0] = start address; the remaining bits are ignored. On the 8th sample: latch the pointer and RW, load tx_shift = regfile[addr], go to DATA.
  - DATA: count DATA_WIDTH sample edges per word.
    - Write: on the last sample of a word, in that same clk, regfile[ptr] <= word. wr_valid pulses with wr_addr = ptr and wr_data = word.
    - Read: on each shift_edge, miso <= tx_shift MSB and tx_shift shifts left. On the last sample of a word, tx_shift reloads from regfile[ptr+1].
    - After each word, ptr = ptr+1 mod 2^ADDR_WIDTH (wraps with no error).
  - Any state -> IDLE when synchronised cs rises. frame_done pulses one clk if the state was CMD or DATA. A partial word is discarded and the regfile is unchanged.
- miso:
  - 0 in IDLE and in CMD before the data phase.
  - During read DATA it changes only on shift edges. For CPHA=0 the first data MSB appears on the trailing edge of command bit 8; for CPHA=1 it appears on the leading edge of data bit 1.
  - During a write frame miso = 0.
- Read and write in the same clk: when a word completes a write and the read reload targets the same address, the reload returns the new data (write-first).
- local_rdata always reflects the regfile, including a write committed in the previous clk.
- sclk edges while cs is high are ignored. cs falling and an sclk edge in the same synchronised clk: the edge is ignored.

Test Plan:
1. Mode 0, DATA_WIDTH=8, ADDR_WIDTH=4; frame 0x03 then 0xA5 -> wr_valid pulses once with wr_addr=3, wr_data=0xA5; local_addr=3 gives local_rdata=0xA5; frame_done pulses once after cs rises.
2. After scenario 1, read frame 0x83 then 8 dummy clocks -> miso bits 1,0,1,0,0,1,0,1 at sample edges; wr_valid stays 0.
3. Burst write at address 14: 0x0E, 0x11, 0x22, 0x33 -> regfile[14]=0x11, [15]=0x22, [0]=0x33 (wrap); three wr_valid pulses.
4. Repeat scenarios 1–2 for modes (CPOL,CPHA) = (0,1), (1,0), (1,1) -> identical register contents and identical miso bit sequences.
5. Write frame 0x05 then 0xFF, with cs raised after 5 data bits -> no wr_valid; regfile[5] unchanged (0); frame_done pulses; a following frame works normally.
6. Assert reset_n low mid-read at data bit 3 -> next clk: miso=0, FSM IDLE, all regfile words 0. After release, frame 0x01, 0x7E -> regfile[1]=0x7E.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: oversampled SPI slave decoding cmd/data frames into a regfile.
// Ports: clk/reset_n, SPI sclk/mosi/cs/miso, local read port, write-notify, frame_done.
module spi_slave_regfile #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso,
  input  logic [ADDR_WIDTH-1:0] local_addr,
  output logic [DATA_WIDTH-1:0] local_rdata,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = 6;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   rise;
  logic                   fall;
  logic                   lead;
  logic                   trail;
  logic                   sample;
  logic                   shift;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   last_bit;
  logic                   rw;
  logic [CW-1:0]          bitcnt;
  logic [ADDR_WIDTH-1:0]  a_sh;
  logic [ADDR_WIDTH-1:0]  a_next;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [ADDR_WIDTH-1:0]  ptr_nxt;
  logic [DATA_WIDTH-1:0]  rx_sh;
  logic [DATA_WIDTH-1:0]  rx_next;
  logic [DATA_WIDTH-1:0]  tx_sh;
  logic [DATA_WIDTH-1:0]  reload;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;
  assign lead    = (CPOL == 0) ? rise : fall;
  assign trail   = (CPOL == 0) ? fall : rise;
  assign sample  = (CPHA == 0) ? lead : trail;
  assign shift   = (CPHA == 0) ? trail : lead;

  // Only the low address bits of the command survive the truncation.
  assign a_next   = ADDR_WIDTH'({a_sh, mosi_s});
  assign rx_next  = DATA_WIDTH'({rx_sh, mosi_s});
  assign ptr_nxt  = ptr + ADDR_WIDTH'(1);
  assign last_bit = (bitcnt == CW'(DATA_WIDTH - 1));

  // A write landing on the reload address in the same clk wins.
  assign reload = (!rw && ptr_nxt == ptr) ? rx_next : mem[ptr_nxt];

  assign local_rdata = mem[local_addr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_q     <= '0;
      mosi_q     <= '0;
      cs_q       <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b0;
      state      <= IDLE;
      bitcnt     <= '0;
      a_sh       <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      miso       <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], cs};
      sclk_d     <= sclk_s;
      cs_d       <= cs_s;
      wr_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (cs_rise) begin
        state      <= IDLE;
        miso       <= 1'b0;
        frame_done <= (state != IDLE);
      end else begin
        unique case (state)
          IDLE: begin
            // An sclk edge coinciding with cs fall is dropped here.
            if (cs_fall) begin
              state  <= CMD;
              bitcnt <= '0;
              a_sh   <= '0;
              rx_sh  <= '0;
              miso   <= 1'b0;
            end
          end
          CMD: begin
            if (sample) begin
              a_sh <= a_next;
              if (bitcnt == '0) rw <= mosi_s;
              if (bitcnt == CW'(7)) begin
                ptr    <= a_next;
                tx_sh  <= mem[a_next];
                bitcnt <= '0;
                state  <= DATA;
              end else begin
                bitcnt <= bitcnt + CW'(1);
              end
            end
          end
          DATA: begin
            if (sample) begin
              rx_sh <= rx_next;
              if (last_bit) begin
                bitcnt <= '0;
                ptr    <= ptr_nxt;
                tx_sh  <= reload;
                if (!rw) begin
                  mem[ptr] <= rx_next;
                  wr_valid <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= rx_next;
                end
              end else begin
                bitcnt <= bitcnt + CW'(1);
              end
            end else if (shift && rw) begin
              miso  <= tx_sh[DATA_WIDTH-1];
              tx_sh <= tx_sh << 1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
